keys_sched_ctrl: RTL and testbench

Controller for the 32-entry round-key buffer in the SM4 core.
- Load side: sequences writes of the round keys produced by the key-expansion unit into buffer addresses 0..31.
- Crypt side: once all keys are present, generates one read address per pipeline stage every cycle (forward order for encrypt, reverse order for decrypt) and drives the buffer's stall input.
- Sits between the key-expansion unit, the round-key buffer and the round pipeline.

---
 rtl/keys_sched_ctrl_pkg.sv | 21 ++
 rtl/keys_sched_ctrl_if.sv | 22 ++
 rtl/keys_raddr_gen.sv | 20 ++
 rtl/keys_sched_ctrl.sv | 118 +++++++++++
 tb/tb_keys_sched_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/keys_sched_ctrl_pkg.sv
// Shared constants and FSM encoding for the SM4 round-key schedule controller.
// Optional error reporting is enabled with KEYS_SCHED_ERR_EN.
package keys_sched_ctrl_pkg;

   localparam int KEY_EXPAND_NUM = 32;
   localparam int ROUND_NUM      = 32;
   localparam int ADDR_WIDTH     = 5;
   localparam int PIPE_DEPTH     = 4;
   localparam int WORD_WIDTH     = 32;

   localparam int ITERS      = ROUND_NUM / PIPE_DEPTH;
   localparam int ITER_WIDTH = $clog2(ITERS);
   localparam int RADDR_W    = ADDR_WIDTH * PIPE_DEPTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/keys_sched_ctrl_if.sv
// Round-key buffer port bundle: write side and packed per-stage read side.
// The controller drives it through the master modport.
interface keys_sched_ctrl_if;
   import keys_sched_ctrl_pkg::*;

   logic                  buf_w_en;
   logic [ADDR_WIDTH-1:0] buf_w_addr;
   logic [WORD_WIDTH-1:0] buf_data_in;
   logic [RADDR_W-1:0]    buf_r_addr;
   logic                  buf_stall;

   modport master (
      output buf_w_en, buf_w_addr, buf_data_in,
      output buf_r_addr, buf_stall
   );

   modport slave (
      input buf_w_en, buf_w_addr, buf_data_in,
      input buf_r_addr, buf_stall
   );

endinterface

// File: rtl/keys_raddr_gen.sv
// Per-stage read address: stage base plus iteration, mirrored for decrypt.
module keys_raddr_gen
   import keys_sched_ctrl_pkg::*;
#(
   parameter int STAGE = 0
) (
   input  logic [ITER_WIDTH-1:0] iter,
   input  logic                  dec,
   output logic [ADDR_WIDTH-1:0] addr
);

   localparam logic [ADDR_WIDTH-1:0] OFS = ADDR_WIDTH'(STAGE * ITERS);
   localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(ROUND_NUM - 1);

   logic [ADDR_WIDTH-1:0] base;

   assign base = OFS + ADDR_WIDTH'(iter);
   assign addr = dec ? (TOP - base) : base;

endmodule

// File: rtl/keys_sched_ctrl.sv
// SM4 round-key buffer controller: key load sequencing and per-stage reads.
// Define KEYS_SCHED_ERR_EN to add the sticky err output and stall watchdog.
module keys_sched_ctrl
   import keys_sched_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   key_load,
   input  logic                   dec_mode,
   input  logic                   kx_valid,
   input  logic [WORD_WIDTH-1:0]  kx_rk,
   input  logic                   stall,
   keys_sched_ctrl_if.master      bus,
   output logic                   keys_ready,
   output logic                   blk_accept,
`ifdef KEYS_SCHED_ERR_EN
   output logic                   err,
`endif
   output logic [ITER_WIDTH-1:0]  iter
);

   localparam logic [ADDR_WIDTH-1:0] LAST_W =
      ADDR_WIDTH'(KEY_EXPAND_NUM - 1);
   localparam logic [ITER_WIDTH-1:0] LAST_I =
      ITER_WIDTH'(ITERS - 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] wcnt;
   logic                  dec;
   logic [RADDR_W-1:0]    raddr_q;
   logic [RADDR_W-1:0]    raddr_nxt;
   logic [ITER_WIDTH-1:0] iter_nxt;
   logic                  run;
   logic                  wr;

   assign run = (state == S_RUN);
   assign wr  = kx_valid & (state == S_LOAD) & ~key_load;

   always_comb begin
      iter_nxt = iter;
      if (run)
         iter_nxt = (iter == LAST_I) ? '0 : iter + 1'b1;
   end

   for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
      keys_raddr_gen #(.STAGE(i)) u_gen (
         .iter (iter_nxt),
         .dec  (dec),
         .addr (raddr_nxt[ADDR_WIDTH*i +: ADDR_WIDTH])
      );
   end

   assign bus.buf_w_en    = wr;
   assign bus.buf_w_addr  = wcnt;
   assign bus.buf_data_in = wr ? kx_rk : '0;
   assign bus.buf_r_addr  = raddr_q;
   assign bus.buf_stall   = stall | ~run;
   assign blk_accept      = run & (iter == '0) & ~stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wcnt       <= '0;
         iter       <= '0;
         dec        <= 1'b0;
         keys_ready <= 1'b0;
         raddr_q    <= '0;
      end else if (key_load) begin
         state      <= S_LOAD;
         wcnt       <= '0;
         iter       <= '0;
         dec        <= dec_mode;
         keys_ready <= 1'b0;
      end else begin
         unique case (state)
            S_LOAD: if (kx_valid) begin
               wcnt <= wcnt + 1'b1;
               // last key: publish stage addresses for iteration 0
               if (wcnt == LAST_W) begin
                  state      <= S_RUN;
                  keys_ready <= 1'b1;
                  raddr_q    <= raddr_nxt;
               end
            end
            S_RUN: if (!stall) begin
               iter    <= iter_nxt;
               raddr_q <= raddr_nxt;
            end
            default: ;
         endcase
      end
   end

`ifdef KEYS_SCHED_ERR_EN
   logic [7:0] wdog;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err  <= 1'b0;
         wdog <= '0;
      end else if (key_load) begin
         err  <= 1'b0;
         wdog <= '0;
      end else begin
         if (run && stall) begin
            wdog <= wdog + 8'd1;
            if (wdog == 8'hff)
               err <= 1'b1;
         end else begin
            wdog <= '0;
         end
         if (kx_valid && state != S_LOAD)
            err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_keys_sched_ctrl.sv
// Directed bench for keys_sched_ctrl: load, encrypt/decrypt reads, stall, abort.
module tb_keys_sched_ctrl;

   logic        clk;
   logic        rst_n;
   logic        key_load;
   logic        dec_mode;
   logic        kx_valid;
   logic [31:0] kx_rk;
   logic        stall;
   logic        keys_ready;
   logic        blk_accept;
   logic [2:0]  iter;
`ifdef KEYS_SCHED_ERR_EN
   logic        err;
`endif

   int errors = 0;
   int checks = 0;

   keys_sched_ctrl_if bus ();

   keys_sched_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_load   (key_load),
      .dec_mode   (dec_mode),
      .kx_valid   (kx_valid),
      .kx_rk      (kx_rk),
      .stall      (stall),
      .bus        (bus),
      .keys_ready (keys_ready),
      .blk_accept (blk_accept),
`ifdef KEYS_SCHED_ERR_EN
      .err        (err),
`endif
      .iter       (iter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // stage i reads round i*8+it (encrypt) or 31-(i*8+it) (decrypt)
   function automatic logic [19:0] exp_addr(input int it, input bit d);
      logic [19:0] r;
      int a;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         a = i * 8 + it;
         r[5*i +: 5] = d ? 5'(31 - a) : 5'(a);
      end
      return r;
   endfunction

   task automatic load_keys(input bit d, input logic [31:0] seed);
      key_load = 1'b1;
      dec_mode = d;
      tick();
      key_load = 1'b0;
      chk("load_ready_low", keys_ready, 0);
      for (int n = 0; n < 32; n++) begin
         kx_valid = 1'b1;
         kx_rk    = seed + n;
         #1;
         chk("wr_en", bus.buf_w_en, 1);
         chk("wr_addr", bus.buf_w_addr, n);
         chk("wr_data", bus.buf_data_in, seed + n);
         if (n == 31) chk("ready_before_last", keys_ready, 0);
         tick();
      end
      kx_valid = 1'b0;
      chk("ready_after_last", keys_ready, 1);
      chk("run_iter0", iter, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      key_load = 1'b0;
      dec_mode = 1'b0;
      kx_valid = 1'b0;
      kx_rk    = '0;
      stall    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", keys_ready, 0);
      chk("rst_accept", blk_accept, 0);
      chk("rst_wen", bus.buf_w_en, 0);
      chk("rst_waddr", bus.buf_w_addr, 0);
      chk("rst_wdata", bus.buf_data_in, 0);
      chk("rst_raddr", bus.buf_r_addr, 0);
      chk("rst_bstall", bus.buf_stall, 1);
      chk("rst_iter", iter, 0);
      rst_n = 1'b1;
      tick();

      // reset in the middle of a load
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      for (int n = 0; n < 10; n++) begin
         kx_valid = 1'b1;
         kx_rk    = 32'h2000 + n;
         tick();
      end
      chk("midload_addr", bus.buf_w_addr, 10);
      chk("midload_wen", bus.buf_w_en, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_wen", bus.buf_w_en, 0);
      chk("arst_waddr", bus.buf_w_addr, 0);
      chk("arst_wdata", bus.buf_data_in, 0);
      chk("arst_bstall", bus.buf_stall, 1);
      chk("arst_ready", keys_ready, 0);
      #2;
      rst_n = 1'b1;
      tick();
      #1;
      chk("idle_kx_ignored", bus.buf_w_en, 0);
      chk("idle_ready", keys_ready, 0);
      chk("idle_raddr", bus.buf_r_addr, 0);
      kx_valid = 1'b0;
      tick();

      // encrypt load and run
      load_keys(1'b0, 32'h1000);
      chk("enc_first_set", bus.buf_r_addr, {5'd24, 5'd16, 5'd8, 5'd0});
      chk("enc_bstall", bus.buf_stall, 0);
      kx_valid = 1'b1;
      kx_rk    = 32'hBAD0_0000;
      #1;
      chk("run_kx_ignored", bus.buf_w_en, 0);
      for (int c = 0; c < 17; c++) begin
         if (c == 1) begin
            kx_valid = 1'b0;
`ifdef KEYS_SCHED_ERR_EN
            chk("err_set", err, 1);
`endif
         end
         chk("enc_iter", iter, c % 8);
         chk("enc_raddr", bus.buf_r_addr, exp_addr(c % 8, 1'b0));
         chk("enc_accept", blk_accept, (c % 8) == 0);
         if (c == 7)
            chk("enc_last_set", bus.buf_r_addr,
                {5'd31, 5'd23, 5'd15, 5'd7});
         tick();
      end
      chk("enc_wrap_iter", iter, 1);
      repeat (4) tick();
      chk("pre_stall_iter", iter, 5);

      // stall at iter 5
      stall = 1'b1;
      #1;
      chk("stall_bstall", bus.buf_stall, 1);
      chk("stall_accept", blk_accept, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_iter", iter, 5);
         chk("stall_raddr", bus.buf_r_addr, {5'd29, 5'd21, 5'd13, 5'd5});
      end
      stall = 1'b0;
      #1;
      chk("unstall_bstall", bus.buf_stall, 0);
      tick();
      chk("resume_iter", iter, 6);
      chk("resume_raddr", bus.buf_r_addr, {5'd30, 5'd22, 5'd14, 5'd6});

      // abort mid-run at iter 3 with a colliding key write
      repeat (5) tick();
      chk("abort_iter", iter, 3);
      key_load = 1'b1;
      dec_mode = 1'b1;
      kx_valid = 1'b1;
      kx_rk    = 32'hDEAD_BEEF;
      #1;
      chk("abort_wdrop", bus.buf_w_en, 0);
      tick();
      key_load = 1'b0;
      kx_valid = 1'b0;
      chk("abort_ready", keys_ready, 0);
      chk("abort_bstall", bus.buf_stall, 1);
      chk("abort_iter0", iter, 0);
      chk("abort_waddr", bus.buf_w_addr, 0);
`ifdef KEYS_SCHED_ERR_EN
      chk("err_cleared", err, 0);
`endif

      // decrypt reload (starts with its own key_load)
      load_keys(1'b1, 32'h5000);
      chk("dec_first_set", bus.buf_r_addr, {5'd7, 5'd15, 5'd23, 5'd31});
      chk("dec_accept", blk_accept, 1);
      tick();
      chk("dec_second_set", bus.buf_r_addr, {5'd6, 5'd14, 5'd22, 5'd30});
      chk("dec_second_model", bus.buf_r_addr, exp_addr(1, 1'b1));
      chk("dec_no_accept", blk_accept, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
